// File: rtl/sm_seg_pkg.sv
// Shared constants for the seven-segment display path: hex glyphs {g,f,e,d,c,b,a}
// and the width of the brightness field.
package sm_seg_pkg;

  localparam int unsigned BRIGHT_W = 4;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/sm_hex_display.sv
// Combinational hex nibble to seven-segment decoder (logical polarity, 1 = lit).
module sm_hex_display
  import sm_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sm_seg_mux.sv
// Multiplexed seven-segment driver with double-buffered digits and PWM brightness.
// Define SM_SEG_LZB_EN to blank leading zero digits (segments only).
module sm_seg_mux
  import sm_seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_LOG2   = 10,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dpIn,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frameTick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [REFRESH_LOG2-1:0] cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*DIGITS-1:0]     stage_data_q, disp_data_q;
  logic [DIGITS-1:0]       stage_dp_q, disp_dp_q;
  logic [DIGITS-1:0]       anode_q, anode_d;
  logic [6:0]              seg_q, seg_d, hex_seg;
  logic                    dp_q, dp_d, tick_q;

  logic       slot_end, frame_end, lit, dp_sel, digit_blank;
  logic [3:0] nibble;

  assign slot_end  = enable & (cnt_q == '1);
  assign frame_end = slot_end & (idx_q == LAST_IDX);
  // PWM: the top bits of the slot counter sweep 0..15 once per slot.
  assign lit       = enable & (cnt_q[REFRESH_LOG2-1 -: BRIGHT_W] <= bright);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + REFRESH_LOG2'(1);
      if (slot_end) idx_q <= frame_end ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display register only changes at frame boundaries; a coincident load bypasses staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data_q <= '0;
      stage_dp_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
    end else begin
      if (load) begin
        stage_data_q <= data;
        stage_dp_q   <= dpIn;
      end
      if (frame_end) begin
        disp_data_q <= load ? data : stage_data_q;
        disp_dp_q   <= load ? dpIn : stage_dp_q;
      end
    end
  end

  always_comb begin
    nibble = '0;
    dp_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble = disp_data_q[4*i +: 4];
        dp_sel = disp_dp_q[i];
      end
    end
  end

`ifdef SM_SEG_LZB_EN
  always_comb begin
    digit_blank = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_blank = ((disp_data_q >> (4 * i)) == '0);
    end
  end
`else
  assign digit_blank = 1'b0;
`endif

  sm_hex_display u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    anode_d = '0;
    seg_d   = SEG_OFF;
    dp_d    = 1'b0;
    if (lit) begin
      anode_d = DIGITS'(1) << idx_q;
      seg_d   = digit_blank ? SEG_OFF : hex_seg;
      dp_d    = dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= frame_end;
    end
  end

  assign anode     = anode_q ^ {DIGITS{AN_ACTIVE_LOW}};
  assign seg       = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp        = dp_q ^ SEG_ACTIVE_LOW;
  assign frameTick = tick_q;

endmodule

// File: tb/tb_sm_seg_mux.sv
// Bench for sm_seg_mux (DIGITS=4, REFRESH_LOG2=4): per-cycle scoreboard plus directed frames.
module tb_sm_seg_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dpIn = '0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frameTick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_seg_mux #(
    .DIGITS         (4),
    .REFRESH_LOG2   (4),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .data      (data),
    .dpIn      (dpIn),
    .bright    (bright),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .frameTick (frameTick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Scoreboard: behavioural model pushes the output expected one cycle later.
  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e, c_e;
  logic [15:0] m_stage = '0, m_disp = '0;
  logic [3:0]  m_sdp = '0, m_ddp = '0;
  int          m_cnt = 0, m_idx = 0;
  logic        m_bnd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_stage = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_cnt = 0; m_idx = 0;
      sb_q.delete();
    end else begin
      m_e = '0;
      if (enable && m_cnt <= int'(bright)) begin
        m_e.anode = 4'(1 << m_idx);
        m_e.seg   = hex7(m_disp[m_idx*4 +: 4]);
`ifdef SM_SEG_LZB_EN
        if (m_idx != 0 && (m_disp >> (4 * m_idx)) == 16'h0) m_e.seg = 7'h00;
`endif
        m_e.dp = m_ddp[m_idx];
      end
      m_bnd  = enable && m_cnt == 15 && m_idx == 3;
      m_e.ft = m_bnd;
      sb_q.push_back(m_e);
      if (m_bnd) begin
        m_disp = load ? data : m_stage;
        m_ddp  = load ? dpIn : m_sdp;
      end
      if (load) begin
        m_stage = data;
        m_sdp   = dpIn;
      end
      if (enable) begin
        if (m_cnt == 15) m_idx = (m_idx == 3) ? 0 : m_idx + 1;
        m_cnt = (m_cnt + 1) % 16;
      end
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      c_e = sb_q.pop_front();
      chk("sb_anode", anode, c_e.anode);
      chk("sb_seg", seg, c_e.seg);
      chk("sb_dp", dp, c_e.dp);
      chk("sb_frametick", frameTick, c_e.ft);
    end
  end

  task automatic wait_ft(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frameTick !== 1'b1 && n < 300);
    chk({name, "_seen"}, frameTick, 1'b1);
  endtask

  // Starts at a frameTick cycle; checks each slot's first and last cycle and ends on the next tick.
  task automatic check_frame(input string name, input logic [3:0][6:0] segs,
                             input logic [3:0] dps);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      load = 1'b0;
      chk({name, "_anode_first"}, anode, 32'(1 << s));
      chk({name, "_seg"}, seg, segs[s]);
      chk({name, "_dp"}, dp, dps[s]);
      repeat (15) @(negedge clk);
      chk({name, "_anode_last"}, anode, 32'(1 << s));
      chk({name, "_frametick"}, frameTick, (s == 3) ? 1 : 0);
    end
  endtask

  function automatic logic [3:0][6:0] mk(input logic [6:0] s0, input logic [6:0] s1,
                                          input logic [6:0] s2, input logic [6:0] s3);
    logic [3:0][6:0] r;
    r[0] = s0; r[1] = s1; r[2] = s2; r[3] = s3;
    return r;
  endfunction

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t            vecs[5];
  logic [3:0][6:0] prev_segs;
  logic [3:0]      prev_dp;
  int              n, on_cnt, bad_cnt;

  initial begin
    vecs[0] = '{data: 16'h1234, dp: 4'b0000, segs: mk(7'h66, 7'h4F, 7'h5B, 7'h06)};
    vecs[1] = '{data: 16'hABCD, dp: 4'b0101, segs: mk(7'h5E, 7'h39, 7'h7C, 7'h77)};
    vecs[2] = '{data: 16'hE90F, dp: 4'b0000, segs: mk(7'h71, 7'h3F, 7'h6F, 7'h79)};
`ifdef SM_SEG_LZB_EN
    vecs[3] = '{data: 16'h0070, dp: 4'b1000, segs: mk(7'h3F, 7'h07, 7'h00, 7'h00)};
    prev_segs = mk(7'h3F, 7'h00, 7'h00, 7'h00);
`else
    vecs[3] = '{data: 16'h0070, dp: 4'b1000, segs: mk(7'h3F, 7'h07, 7'h3F, 7'h3F)};
    prev_segs = mk(7'h3F, 7'h3F, 7'h3F, 7'h3F);
`endif
    vecs[4] = '{data: 16'h1234, dp: 4'b0000, segs: mk(7'h66, 7'h4F, 7'h5B, 7'h06)};
    prev_dp = 4'b0000;

    #1;
    chk("reset_anode", anode, 0);
    chk("reset_seg", seg, 0);
    chk("reset_dp", dp, 0);
    chk("reset_frametick", frameTick, 0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    bright = 4'hF;

    // Each vector is loaded at slot 0 and must only appear in the following frame.
    wait_ft("first_frame", n);
    for (int v = 0; v < 5; v++) begin
      data = vecs[v].data;
      dpIn = vecs[v].dp;
      load = 1'b1;
      check_frame("vec_prev", prev_segs, prev_dp);
      prev_segs = vecs[v].segs;
      prev_dp   = vecs[v].dp;
    end
    check_frame("vec_last", prev_segs, prev_dp);

    // Tear-free: load during slot 1, slots 2..3 keep the old digits.
    repeat (20) @(negedge clk);
    data = 16'hABCD; dpIn = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (12) @(negedge clk);
    chk("tear_slot2_anode", anode, 4'b0100);
    chk("tear_slot2_seg", seg, 7'h5B);
    repeat (16) @(negedge clk);
    chk("tear_slot3_anode", anode, 4'b1000);
    chk("tear_slot3_seg", seg, 7'h06);
    repeat (15) @(negedge clk);
    chk("tear_frametick", frameTick, 1'b1);
    check_frame("tear_new", mk(7'h5E, 7'h39, 7'h7C, 7'h77), 4'b0000);

    // Load in the boundary cycle goes straight to the display register.
    repeat (63) @(negedge clk);
    data = 16'h5555; dpIn = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("simul_frametick", frameTick, 1'b1);
    check_frame("simul", mk(7'h6D, 7'h6D, 7'h6D, 7'h6D), 4'b1111);

    // Brightness: any 64-cycle window covers each counter value four times.
    for (int b = 0; b < 2; b++) begin
      bright = (b == 0) ? 4'd3 : 4'd0;
      repeat (2) @(negedge clk);
      on_cnt = 0; bad_cnt = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (anode != 4'b0) on_cnt++;
        else if (seg != 7'h00 || dp != 1'b0) bad_cnt++;
      end
      chk((b == 0) ? "bright3_on_cycles" : "bright0_on_cycles", on_cnt, (b == 0) ? 16 : 4);
      chk("bright_blank_leak", bad_cnt, 0);
    end
    bright = 4'hF;

    // Enable low mid-slot: outputs dark, counters frozen, scan resumes in place.
    wait_ft("en_sync", n);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (anode != 4'b0 || seg != 7'h00 || dp != 1'b0 || frameTick != 1'b0) bad_cnt++;
    end
    chk("disabled_outputs", bad_cnt, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_anode", anode, 4'b0001);
    wait_ft("resume", n);
    chk("resume_frame_len", n, 53);

    // Asynchronous reset mid-frame.
    repeat (20) @(negedge clk);
    chk("pre_reset_anode", anode, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_anode", anode, 0);
    chk("async_reset_seg", seg, 0);
    chk("async_reset_dp", dp, 0);
    chk("async_reset_frametick", frameTick, 0);
    @(negedge clk);
    chk("held_reset_anode", anode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_anode", anode, 4'b0001);
    chk("restart_seg", seg, 7'h3F);
    chk("restart_dp", dp, 0);
    wait_ft("restart", n);
    chk("restart_frame_len", n, 63);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/sm_seg_mux.md
# sm_seg_mux

Parametrised multiplexed seven-segment display driver. It time-multiplexes `DIGITS` hex digits onto one shared segment bus, with per-digit decimal points, 16-level PWM brightness and tear-free double-buffered updates. It sits between the GPIO output register of the matrix and the board display pins, and supersedes the fixed 4-digit converter.

## Interface
- `DIGITS`, 4: number of multiplexed digits, 1..8.
- `REFRESH_LOG2`, 10: log2 of clock cycles per digit slot, ≥4.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg` and `dp`.
- `AN_ACTIVE_LOW`, 0: 1 inverts `anode`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable.
- `load`  in  1  one-cycle strobe; captures `data`/`dpIn` into staging.
- `data`  in  4*DIGITS  hex nibbles; digit i = `data[4i+3:4i]`.
- `dpIn`  in  DIGITS  decimal point per digit.
- `bright`  in  4  brightness, 0 = 1/16 duty, 15 = full.
- `anode`  out  DIGITS  one-hot digit select (logical polarity before inversion).
- `seg`  out  7  segments {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point.
- `frameTick`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Prescaler** `cnt[REFRESH_LOG2-1:0]` increments each cycle while `enable=1`.
  - Wraps modulo 2^REFRESH_LOG2.
  - On wrap (slot end), digit index `idx` advances; `DIGITS-1` → 0.
- **Buffers:**
  - `load=1` writes `data`, `dpIn` into the staging register.
  - At frame boundary (slot end with `idx=DIGITS-1`), staging is copied to the display register.
  - If `load` coincides with the boundary, the display register takes `data`/`dpIn` directly (newest wins).
  - `load` while `enable=0` updates staging only.
- **Digit drive:** segments come from the `idx` nibble of the display register through the hex decoder; `dp` = display dp bit for `idx`.
- **Brightness:** anode bit `idx` is active iff `cnt[REFRESH_LOG2-1 -: 4] <= bright`; otherwise all anodes are inactive.
- **Blanking:** `seg` and `dp` are forced off whenever all anodes are inactive.
- **enable=0:**
  - `cnt` and `idx` hold.
  - All anodes inactive, `seg`/`dp` off.
  - `frameTick` = 0.
- **Polarity:** inversion is applied last, on the registered outputs.

## Timing
- All outputs are registered; the output reflects the `cnt`/`idx` state of the previous cycle (1-cycle latency).
- Reset values (logical): `anode`=0, `seg`=0, `dp`=0, `frameTick`=0. Physical levels follow the polarity parameters.
- Internal reset values: `cnt`=0, `idx`=0, staging = 0, display = 0.
- `frameTick` is asserted in the cycle after the boundary, for exactly 1 cycle.
- Display-register update is visible at the first slot of the next frame; no mid-frame change is ever visible.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first slot after release is digit 0.
- Full frame = DIGITS × 2^REFRESH_LOG2 cycles.

## Configuration
- Macro `SM_SEG_LZB_EN` enables leading-zero blanking.
- With it defined:
  - A digit is blanked when it and all higher digits are zero; digit 0 is never blanked.
  - Blanking forces `seg` off only; the anode still scans and `dp` still follows `dpIn`.
- Without it, all digits always display.

## Structure
- Shared package `sm_seg_pkg` holds:
  - segment-pattern constants for 0–F;
  - `SEG_OFF`;
  - the brightness-field width constant (4).
- One sub-module: the existing `sm_hex_display` (nibble → 7 segments), instantiated once on the muxed nibble.
- The remainder is the prescaler, index counter, buffers and output registers in `sm_seg_mux`.

## Test plan
Bench parameters: `DIGITS`=4, `REFRESH_LOG2`=4.

- **Reset/scan:**
  - Stimulus: `data`=0x1234, `load` pulse, `bright`=15, `enable`=1.
  - Response: after the first frame boundary, anode sequence 0001, 0010, 0100, 1000, each held 16 cycles; `seg` = patterns 4, 3, 2, 1; `frameTick` every 64 cycles.
- **Tear-free update:**
  - Stimulus: `load` `data`=0xABCD during slot 1 of a frame.
  - Response: slots 2–3 still show the old value; next frame shows D, C, B, A.
- **Simultaneous load/boundary:**
  - Stimulus: `load` `data`=0x5555 in the boundary cycle.
  - Response: the following frame shows 5 on all digits.
- **Brightness:**
  - Stimulus: `bright`=3.
  - Response: anode active for 4 of 16 cycles per slot; `seg`=0 otherwise.
  - Stimulus: `bright`=0.
  - Response: 1 cycle per slot.
- **Enable/reset:**
  - Stimulus: `enable`=0 mid-slot.
  - Response: anodes 0, counters hold, scan resumes at the same `cnt`.
  - Stimulus: `rst_n` low mid-frame.
  - Response: all outputs 0 asynchronously; restart at digit 0.
- **LZB (`SM_SEG_LZB_EN`):**
  - Stimulus: `data`=0x0070, `dpIn`=0b1000.
  - Response: digits 3 and 2 have `seg` off; digit 3 `dp`=1; digit 1 shows 7; digit 0 shows 0.
